// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/hold sequencing, operand forwarding and event counters.
// Build option: define FORWARDING_EN for forwarding with load-use-only stalls; default stalls on any RAW.
//
// state    | meaning
// RUN      | last cycle advanced normally
// LDSTALL  | last cycle inserted a bubble for a data hazard
// MEMWAIT  | last cycle held the pipe for data memory
// FLUSH    | last cycle squashed wrong-path instructions
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  ex_wreg,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_wreg,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_wreg,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        flush,
  output logic        pipe_hold,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [7:0]  flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_LDSTALL = 2'b01,
    ST_MEMWAIT = 2'b10,
    ST_FLUSH   = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic       data_hazard;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  // $0 is hardwired, so it never counts as a dependency.
  function automatic logic src_hit(input logic [4:0] src, input logic wr_en,
                                   input logic [4:0] wreg);
    return wr_en && (src != 5'd0) && (src == wreg);
  endfunction

`ifdef FORWARDING_EN
  assign data_hazard = ex_memread && ex_regwrite && (ex_wreg != 5'd0) &&
                       ((ex_wreg == id_rs) || (id_uses_rt && (ex_wreg == id_rt)));

  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (src_hit(ex_rs, mem_regwrite, mem_wreg))     fwd_a_sel = 2'b10;
    else if (src_hit(ex_rs, wb_regwrite, wb_wreg))  fwd_a_sel = 2'b01;
    if (src_hit(ex_rt, mem_regwrite, mem_wreg))     fwd_b_sel = 2'b10;
    else if (src_hit(ex_rt, wb_regwrite, wb_wreg))  fwd_b_sel = 2'b01;
  end
`else
  // WB writes are visible to ID in the same cycle, so only EX and MEM writers stall.
  assign data_hazard = src_hit(id_rs, ex_regwrite, ex_wreg) ||
                       src_hit(id_rs, mem_regwrite, mem_wreg) ||
                       (id_uses_rt && (src_hit(id_rt, ex_regwrite, ex_wreg) ||
                                       src_hit(id_rt, mem_regwrite, mem_wreg)));
  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_rs, ex_rt, ex_memread, wb_regwrite, wb_wreg};
`endif

  always_comb begin
    state_d     = ST_RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush       = 1'b0;
    pipe_hold   = 1'b0;
    fwd_a       = fwd_a_sel;
    fwd_b       = fwd_b_sel;
    if (!rst_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      flush      = 1'b1;
      fwd_a      = 2'b00;
      fwd_b      = 2'b00;
    end else if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      state_d    = ST_MEMWAIT;
    end else if (branch_taken) begin
      flush   = 1'b1;
      state_d = ST_FLUSH;
    end else if (data_hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_d     = ST_LDSTALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      stall_cnt <= 16'd0;
      flush_cnt <= 8'd0;
    end else begin
      state_q <= state_d;
      if (!pc_write && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (flush && (flush_cnt != 8'hFF))
        flush_cnt <= flush_cnt + 8'd1;
    end
  end

  assign state = state_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 CLK  in  1  clock; all state updates on rising edge.
REQ-003 RST_N  in  1  asynchronous active-low reset.
REQ-004 ID_RS, ID_RT  in  5 each  source registers of the instruction in IF/ID.
REQ-005 ID_USES_RT  in  1  instruction in ID reads Rt (R-type, store, branch).
REQ-006 EX_RS, EX_RT  in  5 each  source registers held in ID/EX.
REQ-007 EX_REGWRITE, EX_MEMREAD  in  1 each; EX_WREG  in  5  destination register selected in EX.
REQ-008 MEM_REGWRITE  in  1; MEM_WREG  in  5  EX/MEM destination.
REQ-009 WB_REGWRITE  in  1; WB_WREG  in  5  MEM/WB destination.
REQ-010 BRANCH_TAKEN  in  1  EX/MEM Branch AND Zero.
REQ-011 MEM_BUSY  in  1  data memory not ready this cycle.
REQ-012 PC_WRITE, IFID_WRITE  out  1 each  load enables for PC and IF/ID.
REQ-013 IDEX_BUBBLE  out  1  load zero control into ID/EX.
REQ-014 FLUSH  out  1  zero IF/ID, ID/EX and EX/MEM control fields.
REQ-015 PIPE_HOLD  out  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-016 FWD_A, FWD_B  out  2 each  ALU operand source: 00 = regfile, 10 = EX/MEM, 01 = MEM/WB.
REQ-017 STATE  out  2  FSM state: 00 RUN, 01 LDSTALL, 10 MEMWAIT, 11 FLUSH.
REQ-018 STALL_CNT  out  16  saturating count of stall cycles.
REQ-019 FLUSH_CNT  out  8  saturating count of flushes.

Function
REQ-020 Hazard detection and all control outputs SHALL be combinational from the current inputs; the FSM and counters SHALL update on CLK.
REQ-021 A source register equal to 0 SHALL NOT match any destination.
REQ-022 Priority per cycle SHALL be MEM_BUSY > BRANCH_TAKEN > data hazard > none.
REQ-023 On MEM_BUSY: PC_WRITE=0, IFID_WRITE=0, PIPE_HOLD=1, FLUSH=0, IDEX_BUBBLE=0; next state MEMWAIT; the state remains MEMWAIT while MEM_BUSY=1.
REQ-024 On BRANCH_TAKEN without MEM_BUSY: FLUSH=1, PC_WRITE=1, IFID_WRITE=1; next state FLUSH; FLUSH_CNT increments.
REQ-025 On a data hazard alone: PC_WRITE=0, IFID_WRITE=0, IDEX_BUBBLE=1; next state LDSTALL.
REQ-026 With no event: PC_WRITE=1, IFID_WRITE=1, all other control outputs 0; next state RUN.
REQ-027 STALL_CNT SHALL increment in every cycle with PC_WRITE=0, except while RST_N is low.
REQ-028 STALL_CNT SHALL saturate at 0xFFFF and FLUSH_CNT at 0xFF; neither wraps.
REQ-029 FWD_A SHALL be 10 if MEM_REGWRITE and MEM_WREG==EX_RS!=0; else 01 if WB_REGWRITE and WB_WREG==EX_RS!=0; else 00.
REQ-030 FWD_B SHALL follow REQ-029 with EX_RT in place of EX_RS; an EX/MEM match SHALL override a simultaneous MEM/WB match.
REQ-031 A register written in WB SHALL be readable in ID in the same cycle, so WB is never a stall source.

Reset
REQ-032 While RST_N=0: STATE=RUN, STALL_CNT=0, FLUSH_CNT=0, PC_WRITE=0, IFID_WRITE=0, FLUSH=1, IDEX_BUBBLE=0, PIPE_HOLD=0, FWD_A=FWD_B=00.
REQ-033 Reset asserted mid-stall or mid-MEMWAIT SHALL abandon that state immediately.
REQ-034 On the first edge after RST_N rises, the block SHALL behave per REQ-022 to REQ-026.

Configuration
REQ-035 Macro FORWARDING_EN SHALL select the forwarding mode.
REQ-036 With FORWARDING_EN defined: forwarding per REQ-029 and REQ-030; a data hazard is a load-use hazard only, i.e. EX_MEMREAD & EX_REGWRITE & EX_WREG!=0 & (EX_WREG==ID_RS | (ID_USES_RT & EX_WREG==ID_RT)).
REQ-037 Without FORWARDING_EN: FWD_A=FWD_B=00 always; a data hazard is any match of ID_RS, or of ID_RT when ID_USES_RT, against EX_WREG with EX_REGWRITE or against MEM_WREG with MEM_REGWRITE.

Verification
REQ-038 Scenario: lw $2 in EX (EX_MEMREAD=1, EX_WREG=2), ID_RS=2 -> one cycle with PC_WRITE=0, IDEX_BUBBLE=1, STATE=01 next, STALL_CNT=1; then RUN.
REQ-039 Scenario: MEM_WREG=EX_RS=5 and WB_WREG=5, both writers valid -> FWD_A=10; with MEM_REGWRITE=0 -> FWD_A=01; with EX_RS=0 -> FWD_A=00.
REQ-040 Scenario: MEM_BUSY=1 for 3 cycles together with BRANCH_TAKEN=1 and a load-use hazard -> PIPE_HOLD=1 for 3 cycles, FLUSH=0, STALL_CNT=3; FLUSH=1 only in the first cycle after MEM_BUSY drops.
REQ-041 Scenario: BRANCH_TAKEN=1 for one cycle -> FLUSH=1, PC_WRITE=1, FLUSH_CNT=1, STATE=11 next.
REQ-042 Scenario: without FORWARDING_EN, MEM_REGWRITE=1, MEM_WREG=ID_RT=7, ID_USES_RT=1 -> stall; same inputs with FORWARDING_EN -> no stall.
REQ-043 Scenario: preload STALL_CNT=0xFFFE, force 4 stall cycles -> STALL_CNT holds 0xFFFF; RST_N pulse mid-stall -> counters 0 and FLUSH=1 asynchronously.
